gate_response_checker: RTL
==========================

Name: gate_response_checker

Overview:
- Hardware counterpart to the gate-level benches: drives every input combination into a small combinational gate under test (DUT), holds each for a fixed dwell, samples the DUT output and checks it against an expected truth table.
- Reports a pass/fail verdict, an error count and a per-vector mismatch map.
- Sits beside gate labs (e.g. NAND built from NOR) for on-board self-check without a simulator.

Parameters:
- N_IN, 2, number of DUT inputs; vectors applied = 2**N_IN.
- HOLD_CYCLES, 20, clock cycles each vector is held; must be >= 1.
- EXPECT, 4'b0111, expected DUT output per vector (width 2**N_IN); bit k = expected output for input value k. The default is a 2-input NAND.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a run.
- abort  in  1  synchronous abort; returns the block to IDLE.
- dut_q  in  1  DUT output, sampled directly (DUT is combinational).
- vec_out  out  N_IN  DUT input drive; MSB drives input A.
- busy  out  1  high while vectors are being applied.
- done  out  1  high in DONE until the next start, abort or reset.
- pass  out  1  done && err_count == 0.
- err_count  out  N_IN+1  number of mismatching vectors.
- mismatch_map  out  2**N_IN  bit k set if vector k mismatched.
- first_fail  out  N_IN  index of the lowest mismatching vector.
- first_fail_vld  out  1  first_fail holds a valid index.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; every output 0.
- States:
  - IDLE: start=1 -> DRIVE; vec_out=0, hold counter=0, all result outputs cleared.
  - DRIVE: hold counter increments each cycle. At the edge where counter == HOLD_CYCLES-1:
    - compare dut_q against EXPECT[vec_out]; on mismatch set mismatch_map[vec_out] and increment err_count;
    - first mismatch only: load first_fail and set first_fail_vld;
    - clear the counter and increment vec_out.
    - If vec_out was 2**N_IN-1, go to DONE instead: vec_out=0, busy=0, done=1.
  - DONE: results held stable. start=1 clears results and restarts exactly as from IDLE.
- Timing: if start is sampled at edge E0, vector k is sampled at edge E0+(k+1)*HOLD_CYCLES and done rises after edge E0+2**N_IN*HOLD_CYCLES. With defaults, done is visible 80 cycles after the start edge.
- busy is 1 exactly in DRIVE. vec_out changes only at sample edges, so the DUT sees each vector for HOLD_CYCLES cycles.
- start while busy: ignored.
- abort (any state, priority over start): next state IDLE, all outputs cleared. Same cycle as start in IDLE -> stays IDLE.
- HOLD_CYCLES=1: a new vector every cycle; the sample uses the dut_q settled from the previous edge's vec_out.
- err_count saturation: not needed, since the max is 2**N_IN and fits in N_IN+1 bits.
- Reset mid-run: immediate return to IDLE, all outputs 0, no residual results.
- The hold counter width is $clog2(HOLD_CYCLES) (min 1 bit).

Decomposition:
- Shared package gate_lab_pkg holds:
  - the state enum (IDLE, DRIVE, DONE);
  - truth-table constants TT_NAND2=4'b0111, TT_NOR2=4'b0001, TT_AND2=4'b1000, TT_OR2=4'b1110, TT_XOR2=4'b0110 for EXPECT.
- One sub-module is natural: dwell_counter (HOLD_CYCLES parameter; inputs clr and en; output last).
- The FSM and result logic stay in the top module.

Test Plan:
- Bench models dut_q = ~(vec_out[1]&vec_out[0]) with defaults; pulse start -> busy for 80 cycles, done=1, pass=1, err_count=0, mismatch_map=4'b0000, first_fail_vld=0.
- dut_q tied to 1, EXPECT=TT_NAND2 -> err_count=1, mismatch_map=4'b1000, first_fail=3, first_fail_vld=1, pass=0.
- NOR model (~(a|b)) against TT_NAND2 -> err_count=2, mismatch_map=4'b0110, first_fail=1, pass=0.
- Check vec_out sequence 0,1,2,3, each held exactly 20 cycles; extra start pulses at cycles 10 and 50 are ignored. A start in DONE clears results and reruns with identical timing.
- rst_n low at cycle 45 (mid-vector 2) -> all outputs 0 immediately. abort at cycle 30 of a new run -> IDLE, outputs 0 on the next edge. Abort and start together in IDLE -> stays IDLE.
- HOLD_CYCLES=1, N_IN=3, EXPECT=8'b1000_0000 (AND3), correct model -> done 8 cycles after the start edge, pass=1.

Source files
------------

// File: rtl/gate_lab_pkg.sv
// -----------------------------------------------------------------------------
// gate_lab_pkg
// Shared definitions for the gate lab self-check hardware.
//   - state_e   : run-control states of the response checker
//   - TT_*      : 2-input truth tables, bit k = expected output for input k
//                 (input value k = {A,B}, A is the MSB)
// -----------------------------------------------------------------------------
package gate_lab_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   localparam logic [3:0] TT_NAND2 = 4'b0111;
   localparam logic [3:0] TT_NOR2  = 4'b0001;
   localparam logic [3:0] TT_AND2  = 4'b1000;
   localparam logic [3:0] TT_OR2   = 4'b1110;
   localparam logic [3:0] TT_XOR2  = 4'b0110;

endpackage

// File: rtl/gate_response_checker_if.sv
// -----------------------------------------------------------------------------
// gate_response_checker_if
// Bundles the run control, the gate-under-test drive/sense pair and the
// result signals of the response checker.
//   slave  : the checker (consumes start/abort/dut_q, produces everything else)
//   master : the host side (issues start/abort, closes the loop through the
//            gate under test on dut_q, reads the results)
// Parameter N_IN must match the checker's N_IN.
// -----------------------------------------------------------------------------
interface gate_response_checker_if #(
   parameter int N_IN = 2
);
   logic                   start;
   logic                   abort;
   logic                   dut_q;
   logic [N_IN-1:0]        vec_out;
   logic                   busy;
   logic                   done;
   logic                   pass;
   logic [N_IN:0]          err_count;
   logic [(1<<N_IN)-1:0]   mismatch_map;
   logic [N_IN-1:0]        first_fail;
   logic                   first_fail_vld;

   modport master (
      output start, abort, dut_q,
      input  vec_out, busy, done, pass, err_count, mismatch_map,
             first_fail, first_fail_vld
   );

   modport slave (
      input  start, abort, dut_q,
      output vec_out, busy, done, pass, err_count, mismatch_map,
             first_fail, first_fail_vld
   );
endinterface

// File: rtl/gate_response_checker_dwell_counter.sv
// -----------------------------------------------------------------------------
// dwell_counter
// Counts the cycles a vector has been presented to the gate under test.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : force the count to zero (has priority over en)
//   en         : advance the count; wraps to zero after the last cycle
//   last       : count is at HOLD_CYCLES-1 (the sample cycle)
// -----------------------------------------------------------------------------
module dwell_counter #(
   parameter int HOLD_CYCLES = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic last
);

   localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CW-1:0] LAST_VAL = CW'(HOLD_CYCLES - 1);

   logic [CW-1:0] cnt_r;

   // Sample flag decoded from the registered count.
   assign last = (cnt_r == LAST_VAL);

   // Dwell count: cleared on request, wraps after the sample cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {CW{1'b0}};
      end else if (clr) begin
         cnt_r <= {CW{1'b0}};
      end else if (en) begin
         if (last) begin
            cnt_r <= {CW{1'b0}};
         end else begin
            cnt_r <= cnt_r + CW'(1'b1);
         end
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: rtl/gate_response_checker.sv
// -----------------------------------------------------------------------------
// gate_response_checker
// Walks every input combination of a small combinational gate, holds each for
// HOLD_CYCLES clocks, samples the gate output on the last cycle of the dwell
// and checks it against the EXPECT truth table.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.start  : one-cycle run request (ignored while busy)
//   bus.abort  : synchronous return to IDLE, clears all results
//   bus.dut_q  : gate output, sampled directly
//   bus.vec_out: gate input drive, MSB = input A
//   bus.busy / done / pass, err_count, mismatch_map, first_fail(_vld): results
// All outputs are registered.
// -----------------------------------------------------------------------------
module gate_response_checker
   import gate_lab_pkg::*;
#(
   parameter int                   N_IN        = 2,
   parameter int                   HOLD_CYCLES = 20,
   parameter logic [(1<<N_IN)-1:0] EXPECT      = TT_NAND2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   gate_response_checker_if.slave  bus
);

   localparam int              N_VEC    = 1 << N_IN;
   localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

   localparam logic [1:0] IDLE  = ST_IDLE;
   localparam logic [1:0] DRIVE = ST_DRIVE;
   localparam logic [1:0] DONE  = ST_DONE;

   logic [1:0]       state_r;
   logic [1:0]       next_state_s;
   logic [N_IN-1:0]  vec_r;
   logic             busy_r;
   logic             done_r;
   logic             pass_r;
   logic [N_IN:0]    err_r;
   logic [N_VEC-1:0] map_r;
   logic [N_IN-1:0]  ff_r;
   logic             ffv_r;

   logic             last_s;
   logic             cnt_clr_s;
   logic             miss_s;
   logic [N_IN:0]    err_next_s;
   logic [N_VEC-1:0] map_next_s;

   assign bus.vec_out        = vec_r;
   assign bus.busy           = busy_r;
   assign bus.done           = done_r;
   assign bus.pass           = pass_r;
   assign bus.err_count      = err_r;
   assign bus.mismatch_map   = map_r;
   assign bus.first_fail     = ff_r;
   assign bus.first_fail_vld = ffv_r;

   // Counter only runs while vectors are applied; any other state or an
   // abort parks it at zero so each run starts with a full dwell.
   assign cnt_clr_s = (state_r != DRIVE) || bus.abort;

   dwell_counter #(
      .HOLD_CYCLES (HOLD_CYCLES)
   ) u_dwell (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr_s),
      .en    (state_r == DRIVE),
      .last  (last_s)
   );

   // Compare of the current vector and the result values it would produce.
   always_comb begin
      miss_s     = (bus.dut_q != EXPECT[vec_r]);
      err_next_s = err_r + {{N_IN{1'b0}}, miss_s};
      map_next_s = map_r;
      if (miss_s) begin
         map_next_s[vec_r] = 1'b1;
      end else begin
         map_next_s = map_r;
      end
   end

   // Run-control next state; abort overrides everything, including start.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE:    next_state_s = bus.start ? DRIVE : IDLE;
         DRIVE:   next_state_s = (last_s && (vec_r == VEC_LAST)) ? DONE : DRIVE;
         DONE:    next_state_s = bus.start ? DRIVE : DONE;
         default: next_state_s = IDLE;
      endcase
      if (bus.abort) begin
         next_state_s = IDLE;
      end else begin
         next_state_s = next_state_s;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Vector drive and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_r  <= {N_IN{1'b0}};
         busy_r <= 1'b0;
         done_r <= 1'b0;
         pass_r <= 1'b0;
         err_r  <= {(N_IN+1){1'b0}};
         map_r  <= {N_VEC{1'b0}};
         ff_r   <= {N_IN{1'b0}};
         ffv_r  <= 1'b0;
      end else if (bus.abort) begin
         vec_r  <= {N_IN{1'b0}};
         busy_r <= 1'b0;
         done_r <= 1'b0;
         pass_r <= 1'b0;
         err_r  <= {(N_IN+1){1'b0}};
         map_r  <= {N_VEC{1'b0}};
         ff_r   <= {N_IN{1'b0}};
         ffv_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE, DONE: begin
               // A new run wipes the previous verdict before the first vector.
               if (bus.start) begin
                  vec_r  <= {N_IN{1'b0}};
                  busy_r <= 1'b1;
                  done_r <= 1'b0;
                  pass_r <= 1'b0;
                  err_r  <= {(N_IN+1){1'b0}};
                  map_r  <= {N_VEC{1'b0}};
                  ff_r   <= {N_IN{1'b0}};
                  ffv_r  <= 1'b0;
               end
            end
            DRIVE: begin
               if (last_s) begin
                  err_r <= err_next_s;
                  map_r <= map_next_s;
                  // Vectors are walked upward, so the first miss is the lowest.
                  if (miss_s && !ffv_r) begin
                     ff_r  <= vec_r;
                     ffv_r <= 1'b1;
                  end
                  if (vec_r == VEC_LAST) begin
                     vec_r  <= {N_IN{1'b0}};
                     busy_r <= 1'b0;
                     done_r <= 1'b1;
                     pass_r <= (err_next_s == {(N_IN+1){1'b0}});
                  end else begin
                     vec_r <= vec_r + {{(N_IN-1){1'b0}}, 1'b1};
                  end
               end
            end
            default: begin
               vec_r  <= {N_IN{1'b0}};
               busy_r <= 1'b0;
               done_r <= 1'b0;
               pass_r <= 1'b0;
               err_r  <= {(N_IN+1){1'b0}};
               map_r  <= {N_VEC{1'b0}};
               ff_r   <= {N_IN{1'b0}};
               ffv_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule
